// File: rtl/scan_decode_ctrl_pkg.sv
// rtl/scan_decode_ctrl_pkg.sv - shared types and decoder constants for the scan sequencer
package scan_decode_ctrl_pkg;

    typedef logic [2:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // {E1, E2_n, E3_n}
    localparam logic [2:0] DEC_ON  = 3'b100;
    localparam logic [2:0] DEC_OFF = 3'b011;

endpackage

// File: rtl/scan_decode_ctrl_if.sv
// rtl/scan_decode_ctrl_if.sv - control inputs and decoder/strobe outputs of the scan sequencer
interface scan_decode_ctrl_if;
    import scan_decode_ctrl_pkg::*;

    logic       en;
    logic [7:0] digit_mask;
    logic       A0;
    logic       A1;
    logic       A2;
    logic       E1;
    logic       E2_n;
    logic       E3_n;
    digit_t     digit_idx;
    logic       digit_strobe;
    logic       busy;

    modport master (
        output en, digit_mask,
        input  A0, A1, A2, E1, E2_n, E3_n, digit_idx, digit_strobe, busy
    );

    modport slave (
        input  en, digit_mask,
        output A0, A1, A2, E1, E2_n, E3_n, digit_idx, digit_strobe, busy
    );
endinterface

// File: rtl/scan_decode_ctrl_rr_next_sel.sv
// rtl/scan_decode_ctrl_rr_next_sel.sv - wrap-around priority search for the next enabled digit
module rr_next_sel
    import scan_decode_ctrl_pkg::*;
(
    input  logic [7:0] mask,
    input  digit_t     start,
    output digit_t     sel,
    output logic       any
);

    digit_t w_probe;
    logic   w_found;

    // Walk start, start+1, ... wrapping 7->0; the first set bit wins
    always_comb begin
        any     = |mask;
        sel     = start;
        w_found = 1'b0;
        w_probe = start;
        for (int i = 0; i < 8; i++) begin
            w_probe = start + i[2:0];
            if (!w_found && mask[w_probe]) begin
                sel     = w_probe;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_decode_ctrl.sv
// rtl/scan_decode_ctrl.sv - round-robin blank/dwell scan sequencer for a 3-to-8 decoder
module scan_decode_ctrl
    import scan_decode_ctrl_pkg::*;
#(
    parameter int BLANK_CYC = 1000,
    parameter int DWELL_CYC = 99000,
    parameter int CNT_W     = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    scan_decode_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    digit_t           r_addr;
    digit_t           r_nxt;
    logic [2:0]       r_dec;
    logic             r_strobe;
    logic             r_busy;

    state_t           w_state;
    logic [CNT_W-1:0] w_timer;
    digit_t           w_addr;
    digit_t           w_nxt;
    logic             w_strobe;
    logic             w_do_sel;
    digit_t           w_sel;
    logic             w_any;

    rr_next_sel u_rr_next_sel (
        .mask  (bus.digit_mask),
        .start (r_nxt),
        .sel   (w_sel),
        .any   (w_any)
    );

    // Next-state, timer and address decisions; a selection overrides the per-state result
    always_comb begin
        w_state  = r_state;
        w_timer  = r_timer;
        w_addr   = r_addr;
        w_nxt    = r_nxt;
        w_strobe = 1'b0;
        w_do_sel = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.en && w_any) w_do_sel = 1'b1;
            end
            ST_BLANK: begin
                if (!bus.en) begin
                    w_state = ST_IDLE;
                end else if (r_timer == '0) begin
                    w_state = ST_SHOW;
                    w_timer = DWELL_LOAD;
                end else begin
                    w_timer = r_timer - CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (!bus.en) begin
                    w_state = ST_IDLE;
                end else if (r_timer == '0) begin
                    if (w_any) w_do_sel = 1'b1;
                    else       w_state  = ST_IDLE;
                end else begin
                    w_timer = r_timer - CNT_W'(1);
                end
            end
            default: w_state = ST_IDLE;
        endcase
        if (w_do_sel) begin
            w_state  = ST_BLANK;
            w_timer  = BLANK_LOAD;
            w_addr   = w_sel;
            w_nxt    = w_sel + 3'd1;
            w_strobe = 1'b1;
        end
    end

    // State, timer and registered decoder outputs; enables follow the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_addr   <= '0;
            r_nxt    <= '0;
            r_dec    <= DEC_OFF;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_timer  <= w_timer;
            r_addr   <= w_addr;
            r_nxt    <= w_nxt;
            r_dec    <= (w_state == ST_SHOW) ? DEC_ON : DEC_OFF;
            r_strobe <= w_strobe;
            r_busy   <= (w_state != ST_IDLE);
        end
    end

    assign bus.A0           = r_addr[0];
    assign bus.A1           = r_addr[1];
    assign bus.A2           = r_addr[2];
    assign bus.E1           = r_dec[2];
    assign bus.E2_n         = r_dec[1];
    assign bus.E3_n         = r_dec[0];
    assign bus.digit_idx    = r_addr;
    assign bus.digit_strobe = r_strobe;
    assign bus.busy         = r_busy;

endmodule
